// File: rtl/sparc_rf_pkg.sv
// Shared types and widths for the register-file write path.
package sparc_rf_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 2 ** REG_W;

    // One queued write-back request; 70 bits packed.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic              dbl;
        logic [DATA_W-1:0] data_lo;
        logic [DATA_W-1:0] data_hi;
    } rf_wreq_t;

    localparam int unsigned WREQ_W = $bits(rf_wreq_t);

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } seq_state_t;

    // Register of an even/odd pair selected by hi.
    function automatic logic [REG_W-1:0] pair_reg(input logic [REG_W-1:0] rd, input logic hi);
        return {rd[REG_W-1:1], hi};
    endfunction

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Write-back request handshake between pipeline (master) and sequencer (slave).
interface regfile_write_sequencer_if;
    import sparc_rf_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [REG_W-1:0]  req_rd;
    logic              req_dbl;
    logic [DATA_W-1:0] req_data_lo;
    logic [DATA_W-1:0] req_data_hi;

    modport master (
        output req_valid, req_rd, req_dbl, req_data_lo, req_data_hi,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_rd, req_dbl, req_data_lo, req_data_hi,
        output req_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a view of every slot for snooping.
module sync_fifo #(
    parameter  int unsigned WIDTH = 70,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                        clk_i,
    input  logic                        clr_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            din_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            dout_o,
    output logic [CNT_W-1:0]            count_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [DEPTH-1:0][WIDTH-1:0] slots_o,
    output logic [DEPTH-1:0]            valid_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents are only meaningful where valid_o is set.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            slots_o[i] = mem_q[i];
            valid_o[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Buffers write-backs, splits doubles into even/odd writes, drives PW/RW/LE and busy.
module regfile_write_sequencer
    import sparc_rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      Clk,
    input  logic                      Clr,
    regfile_write_sequencer_if.slave  req,
    output logic [DATA_W-1:0]         PW,
    output logic [REG_W-1:0]          RW,
    output logic                      LE,
    output logic [NREG-1:0]           busy,
    output logic                      empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    seq_state_t                      state_q, state_d;
    logic [DATA_W-1:0]               pw_q, pw_d;
    logic [REG_W-1:0]                rw_q, rw_d;
    logic                            le_q, le_d;

    logic                            push, pop;
    logic                            fifo_full, fifo_empty;
    logic [CNT_W-1:0]                fifo_count;
    logic [WREQ_W-1:0]               fifo_dout;
    logic [DEPTH-1:0][WREQ_W-1:0]    fifo_slots;
    logic [DEPTH-1:0]                fifo_valid;
    rf_wreq_t                        head;
    rf_wreq_t                        push_req;
    rf_wreq_t                        slot_e;

    assign req.req_ready = !fifo_full && !Clr;
    assign push          = req.req_valid && req.req_ready;
    assign push_req      = '{rd: req.req_rd, dbl: req.req_dbl,
                             data_lo: req.req_data_lo, data_hi: req.req_data_hi};
    assign head          = rf_wreq_t'(fifo_dout);

    sync_fifo #(
        .WIDTH (WREQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .clr_i   (Clr),
        .push_i  (push),
        .din_i   (push_req),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .slots_o (fifo_slots),
        .valid_o (fifo_valid)
    );

    // State and write-port registers; reset drops any half-done double.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_LO;
            pw_q    <= '0;
            rw_q    <= '0;
            le_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            rw_q    <= rw_d;
            le_q    <= le_d;
        end
    end

    // Next-state: one port slot per cycle; a double holds its entry for two slots.
    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        rw_d    = rw_q;
        le_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_LO: begin
                if (!fifo_empty) begin
                    pw_d = head.data_lo;
                    if (head.dbl) begin
                        rw_d    = pair_reg(head.rd, 1'b0);
                        state_d = S_HI;
                    end else begin
                        rw_d = head.rd;
                        pop  = 1'b1;
                    end
                    le_d = (rw_d != REG_W'(0));
                end
            end
            S_HI: begin
                rw_d    = pair_reg(head.rd, 1'b1);
                pw_d    = head.data_hi;
                le_d    = 1'b1;
                pop     = 1'b1;
                state_d = S_LO;
            end
            default: state_d = S_LO;
        endcase
    end

    // Pending-write bitmap: every queued target plus the register on the port.
    always_comb begin
        busy   = '0;
        slot_e = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_e = rf_wreq_t'(fifo_slots[i]);
            if (fifo_valid[i]) begin
                if (slot_e.dbl) begin
                    busy[pair_reg(slot_e.rd, 1'b0)] = 1'b1;
                    busy[pair_reg(slot_e.rd, 1'b1)] = 1'b1;
                end else begin
                    busy[slot_e.rd] = 1'b1;
                end
            end
        end
        if (le_q) busy[rw_q] = 1'b1;
        busy[0] = 1'b0;
    end

    assign PW    = pw_q;
    assign RW    = rw_q;
    assign LE    = le_q;
    assign empty = (fifo_count == CNT_W'(0)) && !le_q;

endmodule
